// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for branch redirect control.
// Used by branch_redirect_ctrl and branch_target_calc.
package branch_ctrl_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/branch_target_calc.sv
// Branch/jump target adder with 4-byte alignment check.
// Pure combinational; shareable with a future BTB.
module branch_target_calc
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  assign w_base = is_jalr ? rs1 : pc;
  assign w_sum  = w_base + imm;

  // JALR clears bit 0 of the sum; the add wraps mod 2^XLEN
  assign target = {w_sum[XLEN-1:1], w_sum[0] & ~is_jalr};

  // no compressed ISA, so bit 1 set means misaligned
  assign misaligned = target[1];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage redirect sequencer: PC redirect handshake, flushes, trap.
// Optional BRANCH_PERF_EN adds branch performance counters.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            stall_pc,
  output logic            trap_misaligned,
  output logic [XLEN-1:0] trap_tval
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_taken,
  output logic [31:0]     perf_redirect_wait
`endif
);

  localparam logic [3:0] CNT_INIT =
    (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_e          r_state;
  state_e          w_state_n;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_n;
  logic            r_rv;
  logic            w_rv_n;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_n;
  logic            r_trap;
  logic            w_trap_n;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] w_tval_n;

  logic [XLEN-1:0] w_target;
  logic            w_mis;
  logic            w_take;
  logic            w_idle;
  logic            w_accept;

  branch_target_calc #(
    .XLEN(XLEN)
  ) u_calc (
    .pc        (ex_pc),
    .imm       (ex_imm),
    .rs1       (ex_rs1),
    .is_jalr   (ex_is_jalr),
    .target    (w_target),
    .misaligned(w_mis)
  );

  assign w_take = ex_valid &
    (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_taken));
  assign w_idle   = (r_state == IDLE);
  assign w_accept = rst_n & w_take & w_idle;

  // squash younger instructions in the acceptance cycle too
  assign flush_if_id = (w_accept & ~w_mis) | ~w_idle;
  assign flush_id_ex = flush_if_id;
  assign stall_pc    = (r_state == REDIRECT);

  assign redirect_valid  = r_rv;
  assign redirect_pc     = r_pc;
  assign trap_misaligned = r_trap;
  assign trap_tval       = r_tval;

  // next-state and registered-output computation
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rv_n    = r_rv;
    w_pc_n    = r_pc;
    w_trap_n  = 1'b0;
    w_tval_n  = r_tval;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_mis) begin
            w_trap_n = 1'b1;
            w_tval_n = w_target;
          end else begin
            w_state_n = REDIRECT;
            w_rv_n    = 1'b1;
            w_pc_n    = w_target;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          w_rv_n = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            w_state_n = IDLE;
          end else begin
            w_state_n = FLUSH;
            w_cnt_n   = CNT_INIT;
          end
        end
      end
      FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_state_n = IDLE;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_rv_n    = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rv    <= 1'b0;
      r_pc    <= '0;
      r_trap  <= 1'b0;
      r_tval  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rv    <= w_rv_n;
      r_pc    <= w_pc_n;
      r_trap  <= w_trap_n;
      r_tval  <= w_tval_n;
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] r_perf_br;
  logic [31:0] r_perf_tk;
  logic [31:0] r_perf_wait;

  assign perf_branches      = r_perf_br;
  assign perf_taken         = r_perf_tk;
  assign perf_redirect_wait = r_perf_wait;

  // wrapping event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_br   <= '0;
      r_perf_tk   <= '0;
      r_perf_wait <= '0;
    end else begin
      if (ex_valid & ex_is_branch & w_idle)
        r_perf_br <= r_perf_br + 32'd1;
      if (w_accept)
        r_perf_tk <= r_perf_tk + 32'd1;
      if (stall_pc & ~redirect_ready)
        r_perf_wait <= r_perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl.
// Table vectors, directed sequences, random vs reference model.
module tb_branch_redirect_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_is_branch, ex_taken;
  logic        ex_is_jal, ex_is_jalr;
  logic [63:0] ex_pc, ex_imm, ex_rs1;
  logic        redirect_valid, redirect_ready;
  logic [63:0] redirect_pc;
  logic        flush_if_id, flush_id_ex, stall_pc;
  logic        trap_misaligned;
  logic [63:0] trap_tval;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branches, perf_taken, perf_redirect_wait;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .XLEN(64),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .stall_pc       (stall_pc),
    .trap_misaligned(trap_misaligned),
    .trap_tval      (trap_tval)
`ifdef BRANCH_PERF_EN
    ,
    .perf_branches     (perf_branches),
    .perf_taken        (perf_taken),
    .perf_redirect_wait(perf_redirect_wait)
`endif
  );

  typedef struct {
    logic        v, br, tk, jal, jalr;
    logic [63:0] pc, imm, rs1;
    logic        e_fl, e_rv;
    logic [63:0] e_pc;
    logic        e_trap;
    logic [63:0] e_tval;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic drive(logic v, logic br, logic tk, logic jal,
                       logic jalr, logic [63:0] pc, logic [63:0] imm,
                       logic [63:0] rs1, logic rdy);
    ex_valid       = v;
    ex_is_branch   = br;
    ex_taken       = tk;
    ex_is_jal      = jal;
    ex_is_jalr     = jalr;
    ex_pc          = pc;
    ex_imm         = imm;
    ex_rs1         = rs1;
    redirect_ready = rdy;
  endtask

  task automatic idle_in(logic rdy);
    drive(0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in(1'b1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // reference model: pending redirect + remaining shadow cycles
  logic        m_pend;
  logic [63:0] m_pc;
  int          m_shadow;
  logic        m_trap;
  logic [63:0] m_tval;

  task automatic model_check_and_step();
    logic        take, idle, mis;
    logic [63:0] tgt;
    logic        e_fl;
    take = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_taken));
    if (ex_is_jalr) tgt = (ex_rs1 + ex_imm) & ~64'd1;
    else            tgt = ex_pc + ex_imm;
    mis  = tgt[1];
    idle = !m_pend && (m_shadow == 0);
    e_fl = (idle && take && !mis) || !idle;
    chk("rnd_rv", redirect_valid, m_pend);
    chk("rnd_pc", redirect_pc, m_pc);
    chk("rnd_stall", stall_pc, m_pend);
    chk("rnd_fl_ifid", flush_if_id, e_fl);
    chk("rnd_fl_idex", flush_id_ex, e_fl);
    chk("rnd_trap", trap_misaligned, m_trap);
    chk("rnd_tval", trap_tval, m_tval);
    m_trap = 1'b0;
    if (idle && take) begin
      if (mis) begin
        m_trap = 1'b1;
        m_tval = tgt;
      end else begin
        m_pend = 1'b1;
        m_pc   = tgt;
      end
    end else if (m_pend) begin
      if (redirect_ready) begin
        m_pend   = 1'b0;
        m_shadow = FC;
      end
    end else if (m_shadow > 0) begin
      m_shadow--;
    end
  endtask

  initial begin
    tbl[0] = '{1,1,1,0,0, 64'h1000, 64'h20, 64'h0,
               1,1, 64'h1020, 0, 64'h0};
    tbl[1] = '{1,1,0,0,0, 64'h1000, 64'h20, 64'h0,
               0,0, 64'h0, 0, 64'h0};
    tbl[2] = '{1,0,0,0,1, 64'h0, 64'h0, 64'h2003,
               0,0, 64'h0, 1, 64'h2002};
    tbl[3] = '{1,1,1,0,0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0,
               1,1, 64'h10, 0, 64'h0};
    tbl[4] = '{1,0,0,1,0, 64'h400, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,
               1,1, 64'h3F8, 0, 64'h0};
    tbl[5] = '{0,0,0,1,0, 64'h400, 64'h8, 64'h0,
               0,0, 64'h0, 0, 64'h0};
    tbl[6] = '{1,1,0,1,0, 64'h100, 64'h10, 64'h0,
               1,1, 64'h110, 0, 64'h0};
    tbl[7] = '{1,0,0,0,1, 64'h0, 64'h3, 64'h3001,
               1,1, 64'h3004, 0, 64'h0};
    tbl[8] = '{1,1,1,0,0, 64'h1000, 64'h6, 64'h0,
               0,0, 64'h0, 1, 64'h1006};

    idle_in(1'b0);
    #12;
    chk("rst_rv", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_fl", flush_if_id, 0);
    chk("rst_stall", stall_pc, 0);
    chk("rst_trap", trap_misaligned, 0);
    chk("rst_tval", trap_tval, 0);
    rst_n = 1'b1;
    tick();

    // table vectors, each from a fresh reset
    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive(tbl[i].v, tbl[i].br, tbl[i].tk, tbl[i].jal, tbl[i].jalr,
            tbl[i].pc, tbl[i].imm, tbl[i].rs1, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_flush", i), flush_if_id, tbl[i].e_fl);
      chk($sformatf("v%0d_flush2", i), flush_id_ex, tbl[i].e_fl);
      tick();
      idle_in(1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_rv", i), redirect_valid, tbl[i].e_rv);
      if (tbl[i].e_rv)
        chk($sformatf("v%0d_pc", i), redirect_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_trap", i), trap_misaligned, tbl[i].e_trap);
      if (tbl[i].e_trap)
        chk($sformatf("v%0d_tval", i), trap_tval, tbl[i].e_tval);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_trap_off", i), trap_misaligned, 0);
      for (int k = 0; k < 5; k++) tick();
    end

    // taken BEQ timeline
    do_reset();
    drive(1, 1, 1, 0, 0, 64'h1000, 64'h20, 64'h0, 1'b1);
    @(negedge clk);
    chk("beq_c0_fl", flush_if_id, 1);
    chk("beq_c0_rv", redirect_valid, 0);
    tick();
    idle_in(1'b1);
    @(negedge clk);
    chk("beq_c1_rv", redirect_valid, 1);
    chk("beq_c1_pc", redirect_pc, 64'h1020);
    chk("beq_c1_stall", stall_pc, 1);
    chk("beq_c1_fl", flush_if_id, 1);
    for (int c = 2; c < 4; c++) begin
      tick();
      @(negedge clk);
      chk($sformatf("beq_c%0d_rv", c), redirect_valid, 0);
      chk($sformatf("beq_c%0d_fl", c), flush_id_ex, 1);
      chk($sformatf("beq_c%0d_stall", c), stall_pc, 0);
    end
    tick();
    @(negedge clk);
    chk("beq_c4_fl", flush_if_id, 0);

    // backpressure with an ignored taken branch mid-wait
    do_reset();
    drive(1, 1, 1, 0, 0, 64'h5000, 64'h40, 64'h0, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) drive(1, 1, 1, 0, 0, 64'h9000, 64'h100, 64'h0, 1'b0);
      else        idle_in(1'b0);
      @(negedge clk);
      chk($sformatf("bp%0d_rv", c), redirect_valid, 1);
      chk($sformatf("bp%0d_pc", c), redirect_pc, 64'h5040);
      chk($sformatf("bp%0d_stall", c), stall_pc, 1);
      tick();
    end
    idle_in(1'b1);
    @(negedge clk);
    chk("bp_ready_rv", redirect_valid, 1);
    tick();
    idle_in(1'b1);
    @(negedge clk);
    chk("bp_exit_rv", redirect_valid, 0);
    chk("bp_exit_stall", stall_pc, 0);
    chk("bp_exit_fl", flush_if_id, 1);
    tick();
    tick();
    @(negedge clk);
    chk("bp_idle_fl", flush_if_id, 0);
    chk("bp_keep_pc", redirect_pc, 64'h5040);

    // reset in the middle of REDIRECT
    do_reset();
    drive(1, 1, 1, 0, 0, 64'h6000, 64'h8, 64'h0, 1'b0);
    tick();
    idle_in(1'b0);
    @(negedge clk);
    chk("mr_rv_pre", redirect_valid, 1);
    #2;
    drive(1, 1, 1, 0, 0, 64'h6000, 64'h8, 64'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_rv", redirect_valid, 0);
    chk("mr_pc", redirect_pc, 0);
    chk("mr_stall", stall_pc, 0);
    chk("mr_fl", flush_if_id, 0);
    chk("mr_trap", trap_misaligned, 0);
    idle_in(1'b1);
    #1;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("mr_idle_fl", flush_if_id, 0);
    tick();
    drive(1, 1, 1, 0, 0, 64'h7000, 64'h4, 64'h0, 1'b1);
    @(negedge clk);
    chk("mr_acc_fl", flush_if_id, 1);
    tick();
    idle_in(1'b1);
    @(negedge clk);
    chk("mr_after_rv", redirect_valid, 1);
    chk("mr_after_pc", redirect_pc, 64'h7004);

    // randomized run against the reference model
    do_reset();
    m_pend = 0; m_pc = 0; m_shadow = 0; m_trap = 0; m_tval = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] rp, ri, rr;
      rp = {$urandom, $urandom} & ~64'd3;
      ri = 64'($signed(32'($urandom_range(0, 255)) - 32'd128));
      rr = {$urandom, $urandom};
      if (($urandom % 8) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0;
      drive(($urandom % 5) != 0, $urandom % 2, $urandom % 2,
            ($urandom % 4) == 0, ($urandom % 4) == 0,
            rp, ri, rr, $urandom % 2);
      @(negedge clk);
      model_check_and_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
